// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Holds the PC and fetches words over a req/ack instruction-memory handshake.
// It absorbs variable memory latency with bubbles, a one-word hold buffer and a
// drop state for requests that a branch has made stale.
//
// Handshake: imem_req/imem_addr are registered. Once imem_req rises, it stays high
// and imem_addr stays stable until a cycle in which imem_ack=1 is sampled on a
// rising edge. imem_ack is honoured only while imem_req=1.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Instruction,
    output logic [31:0] PC_out,
    output logic        instr_valid,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DROP  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        req_q, req_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] buf_q, buf_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic        valid_q, valid_d;

    logic        ack_seen;
    logic [31:0] target;
    logic [31:0] pc_next;
    logic        accept;
    logic [31:0] accept_word;

    // Ack only counts against a live request; branch targets are forced word-aligned.
    assign ack_seen = imem_ack & req_q;
    assign target   = {branch_addr[31:2], 2'b00};
    assign pc_next  = pc_q + 32'd4;

    // Next state, PC and hold buffer; decides whether a fetched word is accepted.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        buf_d       = buf_q;
        accept      = 1'b0;
        accept_word = imem_rdata;
        case (state_q)
            ST_FETCH: begin
                if (branch_taken) begin
                    pc_d = target;
                    // A request still in flight must be allowed to complete.
                    if (req_q && !ack_seen) begin
                        state_d = ST_DROP;
                    end
                end else if (ack_seen) begin
                    if (freeze) begin
                        buf_d   = imem_rdata;
                        state_d = ST_HOLD;
                    end else begin
                        accept = 1'b1;
                        pc_d   = pc_next;
                    end
                end
            end
            ST_HOLD: begin
                if (branch_taken) begin
                    pc_d    = target;
                    state_d = ST_FETCH;
                end else if (!freeze) begin
                    accept      = 1'b1;
                    accept_word = buf_q;
                    pc_d        = pc_next;
                    state_d     = ST_FETCH;
                end
            end
            ST_DROP: begin
                if (branch_taken) begin
                    pc_d = target;
                end
                if (ack_seen) begin
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    // Request for the next cycle; DROP keeps the stale address alive until its ack.
    always_comb begin
        req_d  = (state_d != ST_HOLD);
        addr_d = (state_d == ST_DROP) ? addr_q : pc_d;
    end

    // IF/ID register update: flush beats freeze, freeze holds, otherwise word or bubble.
    always_comb begin
        instr_d  = instr_q;
        pc_out_d = pc_out_q;
        valid_d  = valid_q;
        if (branch_taken) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else if (freeze) begin
            valid_d = valid_q;
        end else if (accept) begin
            instr_d  = accept_word;
            pc_out_d = pc_next;
            valid_d  = 1'b1;
        end else begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_FETCH;
            pc_q     <= RESET_PC;
            req_q    <= 1'b0;
            addr_q   <= 32'h0;
            buf_q    <= 32'h0;
            instr_q  <= NOP_INSTR;
            pc_out_q <= 32'h0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_q    <= req_d;
            addr_q   <= addr_d;
            buf_q    <= buf_d;
            instr_q  <= instr_d;
            pc_out_q <= pc_out_d;
            valid_q  <= valid_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign Instruction = instr_q;
    assign PC_out      = pc_out_q;
    assign instr_valid = valid_q;
    assign dbg_state   = state_q;

endmodule
